// File: rtl/fft_dit_iter_core.sv
// fft_dit_iter_core: iterative in-place radix-2 DIT FFT/IFFT with streaming load and unload
module fft_dit_iter_core #(
  parameter int N     = 8,
  parameter int LOG2N = 3,
  parameter int W     = 9,
  parameter int TW    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [W-1:0]    in_re,
  input  logic signed [W-1:0]    in_im,
  input  logic                   in_inverse,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [W-1:0]    out_re,
  output logic signed [W-1:0]    out_im,
  output logic [LOG2N-1:0]       out_index,
  output logic                   out_last,
  output logic                   busy
);
  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;
  // Quarter-wave cosine of a 64-point circle in Q2.14; smaller N strides through it
  localparam logic [14:0] C [32] = '{
    15'd16384, 15'd16305, 15'd16069, 15'd15679, 15'd15137, 15'd14449, 15'd13623, 15'd12665,
    15'd11585, 15'd10394, 15'd9102,  15'd7723,  15'd6270,  15'd4756,  15'd3196,  15'd1606,
    15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0,
    15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0};
  localparam int UP  = TW > 16 ? TW - 16 : 0;
  localparam int DN  = TW < 16 ? 16 - TW : 0;
  localparam int RND = (1 << DN) >> 1;
  state_t state, nxt;
  logic [LOG2N-1:0] load_cnt, unl_cnt, p, q;
  logic [LOG2N-2:0] b;
  logic [2:0] s;
  logic mode, ld_fire, out_fire, last_bf;
  logic signed [W-1:0] mem_re [N];
  logic signed [W-1:0] mem_im [N];
  logic signed [W-1:0] ar, ai, br, bi, top_re, top_im, bot_re, bot_im;
  logic signed [TW-1:0] w_re, w_im;
  logic signed [W+TW-1:0] prr, pii, pri, pir;
  logic signed [W+1:0] tr, ti;
  logic [4:0] k64, ic, is;
  int jj, cv, sv;
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    for (int i = 0; i < LOG2N; i++) bitrev[i] = x[LOG2N-1-i];
  endfunction
  assign in_ready  = state == LOAD;
  assign out_valid = state == UNLOAD;
  assign busy      = state != LOAD;
  assign ld_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_bf   = (&b) && s == 3'(LOG2N - 1);
  assign out_re    = out_valid ? mem_re[unl_cnt] : '0;
  assign out_im    = out_valid ? mem_im[unl_cnt] : '0;
  assign out_index = out_valid ? unl_cnt : '0;
  assign out_last  = out_valid && (&unl_cnt);
  always_comb begin
    nxt = state == LOAD    ? ((ld_fire && (&load_cnt)) ? COMPUTE : LOAD) :
          state == COMPUTE ? (last_bf ? UNLOAD : COMPUTE) :
                             ((out_fire && out_last) ? LOAD : UNLOAD);
  end
  // Butterfly b of stage s: span 2^s, twiddle index expressed on the 64-point circle
  always_comb begin
    jj     = int'(b) & ((1 << s) - 1);
    p      = LOG2N'(((int'(b) >> s) << (s + 1)) | jj);
    q      = LOG2N'(int'(p) + (1 << s));
    k64    = 5'(jj << (5 - int'(s)));
    ic     = k64 > 5'd16 ? 5'd0 - k64 : k64;
    is     = k64 > 5'd16 ? k64 - 5'd16 : 5'd16 - k64;
    cv     = k64 > 5'd16 ? -int'(C[ic]) : int'(C[ic]);
    sv     = int'(C[is]);
    w_re   = TW'(((cv <<< UP) + RND) >>> DN);
    w_im   = TW'((((mode ? sv : -sv) <<< UP) + RND) >>> DN);
    ar     = mem_re[p];
    ai     = mem_im[p];
    br     = mem_re[q];
    bi     = mem_im[q];
    prr    = (W+TW)'(br) * (W+TW)'(w_re);
    pii    = (W+TW)'(bi) * (W+TW)'(w_im);
    pri    = (W+TW)'(br) * (W+TW)'(w_im);
    pir    = (W+TW)'(bi) * (W+TW)'(w_re);
    tr     = (W+2)'((prr >>> (TW - 2)) - (pii >>> (TW - 2)));
    ti     = (W+2)'((pri >>> (TW - 2)) + (pir >>> (TW - 2)));
    top_re = W'(((W+2)'(ar) + tr) >>> 1);
    top_im = W'(((W+2)'(ai) + ti) >>> 1);
    bot_re = W'(((W+2)'(ar) - tr) >>> 1);
    bot_im = W'(((W+2)'(ai) - ti) >>> 1);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= LOAD;
      load_cnt <= '0;
      unl_cnt  <= '0;
      b        <= '0;
      s        <= '0;
      mode     <= 1'b0;
    end else begin
      state <= nxt;
      if (ld_fire) load_cnt <= load_cnt + 1'b1;
      if (ld_fire && load_cnt == '0) mode <= in_inverse;
      if (state == COMPUTE) b <= b + 1'b1;
      if (state == COMPUTE && (&b)) s <= last_bf ? 3'd0 : s + 3'd1;
      if (out_fire) unl_cnt <= unl_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      mem_re[bitrev(load_cnt)] <= in_re;
      mem_im[bitrev(load_cnt)] <= in_im;
    end else if (state == COMPUTE) begin
      mem_re[p] <= top_re;
      mem_im[p] <= top_im;
      mem_re[q] <= bot_re;
      mem_im[q] <= bot_im;
    end
  end
endmodule

// File: tb/tb_fft_dit_iter_core.sv
// tb_fft_dit_iter_core: 8- and 64-point cores checked against a floating-twiddle DFT-by-stages model
module tb_fft_dit_iter_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] iv, ir, inv, ov, ordy, ol, bsy;
  logic signed [8:0] ire [2];
  logic signed [8:0] iim [2];
  logic signed [8:0] ore [2];
  logic signed [8:0] oim [2];
  logic [2:0] idx8;
  logic [5:0] idx64;
  int tests = 0;
  int fails = 0;
  int nidx [2];
  longint xr [2][64];
  longint xi [2][64];
  longint er [2][64];
  longint ei [2][64];

  always #5 clk = ~clk;

  fft_dit_iter_core #(.N(8), .LOG2N(3), .W(9), .TW(16)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_re(ire[0]), .in_im(iim[0]),
    .in_inverse(inv[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_re(ore[0]), .out_im(oim[0]),
    .out_index(idx8), .out_last(ol[0]), .busy(bsy[0]));
  fft_dit_iter_core #(.N(64), .LOG2N(6), .W(9), .TW(16)) u64 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_re(ire[1]), .in_im(iim[1]),
    .in_inverse(inv[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_re(ore[1]), .out_im(oim[1]),
    .out_index(idx64), .out_last(ol[1]), .busy(bsy[1]));

  task automatic chk(input string nm, input longint act, input longint exp, input longint tol = 0);
    tests++;
    if (act > exp + tol || act < exp - tol) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask

  function automatic int cur_idx(input int sel);
    return sel != 0 ? int'(idx64) : int'(idx8);
  endfunction

  function automatic int rev(input int x, input int lg);
    int r = 0;
    for (int i = 0; i < lg; i++) r = (r << 1) | ((x >> i) & 1);
    return r;
  endfunction

  function automatic longint rnd(input real x);
    return x >= 0.0 ? longint'($rtoi(x + 0.5)) : -longint'($rtoi(-x + 0.5));
  endfunction

  function automatic longint wrap(input longint x);
    logic signed [8:0] v;
    v = x[8:0];
    return longint'(v);
  endfunction

  // Stage-by-stage fixed-point DFT: bit-reversed load, groups of span h, twiddles from $cos/$sin
  task automatic model(input int sel, input bit mode);
    int n, lg, h, p, q, k;
    longint mr [64];
    longint mi [64];
    longint wr, wi, tr, ti, ar, ai;
    real ang;
    n = sel != 0 ? 64 : 8;
    lg = sel != 0 ? 6 : 3;
    for (int i = 0; i < n; i++) begin
      mr[rev(i, lg)] = xr[sel][i];
      mi[rev(i, lg)] = xi[sel][i];
    end
    for (int st = 0; st < lg; st++) begin
      h = 1 << st;
      for (int base = 0; base < n; base += 2 * h)
        for (int j = 0; j < h; j++) begin
          p = base + j;
          q = p + h;
          k = j * (n / (2 * h));
          ang = 2.0 * 3.14159265358979 * k / n;
          wr = rnd(16384.0 * $cos(ang));
          wi = mode ? rnd(16384.0 * $sin(ang)) : -rnd(16384.0 * $sin(ang));
          tr = ((mr[q] * wr) >>> 14) - ((mi[q] * wi) >>> 14);
          ti = ((mr[q] * wi) >>> 14) + ((mi[q] * wr) >>> 14);
          ar = mr[p];
          ai = mi[p];
          mr[p] = wrap((ar + tr) >>> 1);
          mi[p] = wrap((ai + ti) >>> 1);
          mr[q] = wrap((ar - tr) >>> 1);
          mi[q] = wrap((ai - ti) >>> 1);
        end
    end
    for (int i = 0; i < n; i++) begin
      er[sel][i] = mr[i];
      ei[sel][i] = mi[i];
    end
  endtask

  task automatic clear(input int sel);
    for (int i = 0; i < 64; i++) begin
      xr[sel][i] = 0;
      xi[sel][i] = 0;
    end
  endtask

  task automatic randomize_frame(input int sel);
    for (int i = 0; i < 64; i++) begin
      xr[sel][i] = longint'($urandom_range(0, 511)) - 256;
      xi[sel][i] = longint'($urandom_range(0, 511)) - 256;
    end
  endtask

  task automatic rst_chk(input int sel);
    chk("rst_in_ready", ir[sel], 1);
    chk("rst_out_valid", ov[sel], 0);
    chk("rst_busy", bsy[sel], 0);
    chk("rst_out_re", ore[sel], 0);
    chk("rst_out_im", oim[sel], 0);
    chk("rst_out_index", cur_idx(sel), 0);
    chk("rst_out_last", ol[sel], 0);
  endtask

  task automatic load(input int sel, input bit mode);
    int i = 0;
    int n = sel != 0 ? 64 : 8;
    while (i < n) begin
      @(posedge clk);
      #1;
      iv[sel]  = $urandom_range(0, 3) != 0;
      ire[sel] = 9'(xr[sel][i]);
      iim[sel] = 9'(xi[sel][i]);
      inv[sel] = i == 0 ? mode : 1'($urandom_range(0, 1));
      if (iv[sel] && ir[sel]) i++;
    end
  endtask

  task automatic compute_wait(input int sel);
    int cnt = 0;
    int cyc = 0;
    bit seen = 0;
    int n = sel != 0 ? 64 : 8;
    int lg = sel != 0 ? 6 : 3;
    while (!ov[sel] && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bsy[sel] && !ov[sel]) cnt++;
      if (ir[sel]) seen = 1;
      iv[sel]  = 1'b1;
      ire[sel] = 9'($urandom_range(0, 511));
    end
    iv[sel] = 1'b0;
    chk("compute_cycles", cnt, n / 2 * lg);
    chk("ready_during_compute", seen, 0);
  endtask

  task automatic unload(input int sel, input bit bp);
    int cyc = 0;
    bit done = 0;
    bit held = 0;
    while (!done) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > 2000) begin
        chk("unload_timeout", 1, 0);
        break;
      end
      if (bp && !held && ov[sel] && cur_idx(sel) == 3) begin
        held = 1;
        ordy[sel] = 1'b0;
        repeat (5) begin
          @(posedge clk);
          #1;
        end
        chk("bp_hold_index", cur_idx(sel), 3);
        chk("bp_hold_re", ore[sel], er[sel][3]);
      end
      ordy[sel] = $urandom_range(0, 3) != 0;
      done = ov[sel] && ordy[sel] && ol[sel];
    end
    @(posedge clk);
    #1;
    ordy[sel] = 1'b0;
    chk("ready_after_frame", ir[sel], 1);
    chk("busy_after_frame", bsy[sel], 0);
    chk("valid_after_frame", ov[sel], 0);
  endtask

  task automatic frame(input int sel, input bit mode, input bit bp);
    model(sel, mode);
    load(sel, mode);
    compute_wait(sel);
    unload(sel, bp);
  endtask

  // Every valid output cycle is compared with the model; the expected bin advances only on handshake
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (!rst) nidx[s] = 0;
      else if (ov[s]) begin
        chk("out_re", ore[s], er[s][nidx[s]]);
        chk("out_im", oim[s], ei[s][nidx[s]]);
        chk("out_index", cur_idx(s), nidx[s]);
        chk("out_last", ol[s], longint'(nidx[s] == (s != 0 ? 63 : 7)));
        if (ordy[s]) nidx[s] = (nidx[s] + 1) % (s != 0 ? 64 : 8);
      end
    end
  end

  initial begin
    iv = '0;
    inv = '0;
    ordy = '0;
    for (int s = 0; s < 2; s++) begin
      ire[s] = '0;
      iim[s] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_chk(0);
    rst_chk(1);
    rst = 1'b1;
    clear(0);
    xr[0][0] = 128;
    model(0, 0);
    for (int i = 0; i < 8; i++) begin
      chk("model_impulse_re", er[0][i], 16);
      chk("model_impulse_im", ei[0][i], 0);
    end
    frame(0, 0, 0);
    clear(0);
    for (int i = 0; i < 8; i++) xr[0][i] = 64;
    model(0, 0);
    chk("model_dc_bin0", er[0][0], 64, 1);
    for (int i = 1; i < 8; i++) chk("model_dc_other", er[0][i], 0, 1);
    frame(0, 0, 0);
    clear(0);
    xr[0][0] = 64;
    model(0, 1);
    chk("model_idft_dc", er[0][5], 8, 1);
    frame(0, 1, 0);
    clear(0);
    xr[0][1] = 64;
    model(0, 1);
    chk("model_idft_x1_n0_re", er[0][0], 8, 1);
    chk("model_idft_x1_n2_re", er[0][2], 0, 1);
    chk("model_idft_x1_n2_im", ei[0][2], 8, 1);
    frame(0, 1, 0);
    randomize_frame(0);
    frame(0, 0, 1);
    clear(0);
    xr[0][0] = 128;
    model(0, 0);
    load(0, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("busy_stage1", bsy[0], 1);
    rst = 1'b0;
    #1;
    rst_chk(0);
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    rst = 1'b1;
    frame(0, 0, 0);
    repeat (6) begin
      randomize_frame(0);
      frame(0, 1'($urandom_range(0, 1)), 0);
    end
    repeat (3) begin
      randomize_frame(1);
      frame(1, 1'($urandom_range(0, 1)), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fft_dit_iter_core.md
Name: fft_dit_iter_core

Overview:
- Parametrised, iterative radix-2 decimation-in-time FFT/IFFT core; successor to the fixed 8-point parallel dit_fft_8.
- Samples stream in one per cycle over a valid/ready handshake and are stored in bit-reversed order in an internal register array.
- The core then runs one butterfly per cycle, in place, and streams results out in natural order.
- Forward or inverse transform is selected per frame; it sits between the sample capture front end and the spectral post-processing.

Parameters:
- N, 8, transform points; power of two, 8..64.
- LOG2N, 3, log2(N); must match N.
- W, 9, signed two's-complement sample width for real and imaginary parts.
- TW, 16, signed twiddle width; Q2.(TW-2) format, so +1.0 = 2^(TW-2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  core accepts a sample this cycle.
- in_re  in  W  input real part.
- in_im  in  W  input imaginary part.
- in_inverse  in  1  mode select; 1 = IFFT; sampled with the first sample of a frame.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output sample.
- out_re  out  W  output real part.
- out_im  out  W  output imaginary part.
- out_index  out  LOG2N  frequency/time bin of the current output.
- out_last  out  1  high on bin N-1.
- busy  out  1  high in COMPUTE and UNLOAD.

Behaviour:
- Reset (rst low, asynchronous):
  - State = LOAD; all counters = 0.
  - in_ready=1; out_valid=0; out_re/out_im/out_index=0; out_last=0; busy=0.
  - Memory contents are don't-care.
- LOAD:
  - in_ready=1. Each handshake (in_valid & in_ready) writes the sample to address bitrev(load_cnt), then increments load_cnt.
  - in_inverse is latched into mode on the handshake where load_cnt=0.
  - On the handshake with load_cnt=N-1, go to COMPUTE next cycle; in_ready drops to 0 that same cycle.
  - Gaps in in_valid are allowed and stall loading.
- COMPUTE:
  - in_ready=0; busy=1.
  - Nested counters: stage s = 0..LOG2N-1, butterfly b = 0..N/2-1. Exactly one butterfly per cycle; duration is exactly (N/2)*LOG2N cycles.
  - Span h = 2^s. Group g = b>>s; j = b & (h-1); top index p = g*2h + j; bottom index q = p + h.
  - Twiddle w = exp(-j*2*pi*j*(N/(2h))/N) for forward; its conjugate for inverse. ROM is indexed by k = j*(N>>(s+1)), holding N/2 entries per part, each round(cos|sin * 2^(TW-2)).
  - t = mem[q]*w. Each real product is arithmetic-shifted right by TW-2 (truncation).
  - mem[p] = (mem[p]+t)>>>1; mem[q] = (mem[p]-t)>>>1. Computed at W+2 bits internally, then truncated to W (no saturation needed given the per-stage halving).
  - Memory reads are combinational; the write happens at the clock edge. There are no read-after-write hazards within a stage.
  - After the last butterfly of the last stage, go to UNLOAD.
- Scaling: the result equals the DFT/N (forward) or the IDFT with 1/N (inverse), within truncation error of ≤ LOG2N LSB.
- UNLOAD:
  - out_valid=1; out_re/out_im = mem[unl_cnt]; out_index = unl_cnt; out_last = (unl_cnt==N-1).
  - Outputs are held stable while out_valid & !out_ready.
  - Each output handshake increments unl_cnt. After the handshake with out_last=1: out_valid=0 and busy=0 next cycle, state = LOAD, in_ready=1.
- Input during COMPUTE/UNLOAD is ignored (in_ready=0); no overlap between frames.
- Asynchronous reset mid-frame aborts immediately; the next frame starts clean from load_cnt=0.

Test Plan:
- N=8, W=9, forward; impulse x[0]=128, all others 0 -> all 8 outputs re=16, im=0; out_index 0..7; out_last on index 7; COMPUTE lasts exactly 12 cycles.
- Forward DC: all x = 64+0j -> bin0 = 64+0j, bins 1..7 = 0 (±1 LSB).
- Inverse: X[0]=64, others 0 -> every output = 8+0j. Inverse with X[1]=64, others 0 -> output n = 8*exp(+j*2*pi*n/8); e.g. n=2 -> 0+8j (±1 LSB).
- Backpressure: hold out_ready=0 for 5 cycles at index 3 -> out_re/out_im/out_index stay unchanged and no bin is skipped or repeated; in_valid asserted during COMPUTE is never accepted.
- Reset during COMPUTE (stage 1): pull rst low for 1 cycle -> all outputs at reset values immediately. Reload the impulse frame -> correct result 16+0j on every bin.
- Random-stimulus regression (N=8 and N=64): $random samples with random in_valid/out_ready gaps -> outputs match a golden model of the same fixed-point algorithm bit-exactly.
